// File: rtl/ad9434_sample_packer.sv
// AD9434 sample packer: rebuilds 12-bit samples from IDDR halves,
// packs 4 per 64-bit AXI-Stream word, buffers them and frames a capture.
//
// Ports:
//   clk, rst_n        DCO-derived clock, async active-low reset
//   enable, start     capture enable (low aborts), one-cycle arm pulse
//   frame_len         words per frame, latched on start
//   q1, q2            IDDR rising/falling halves (D6..D11 / D0..D5)
//   or_q1, or_q2      IDDR overrange halves
//   m_tdata/m_tuser   4 x 16-bit lanes (lane0 oldest) / per-lane overrange
//   m_tvalid/m_tready AXI-Stream handshake, m_tlast on final frame word
//   busy              FSM not idle
//   overflow/ovf_cnt  sticky drop flag / saturating dropped-word count
//   ramp_err_cnt      ramp checker mismatches (AD9434_RAMP_CHK_EN only)
//
// Optional feature macro: AD9434_RAMP_CHK_EN adds the ramp checker.

module ad9434_sample_packer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_LEN_W = 16,
    parameter int SWAP_HALVES = 0,
    parameter int TWOS_COMP   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    input  logic [5:0]             q1,
    input  logic [5:0]             q2,
    input  logic                   or_q1,
    input  logic                   or_q2,
    output logic [63:0]            m_tdata,
    output logic [3:0]             m_tuser,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   busy,
    output logic                   overflow,
    output logic [15:0]            ovf_cnt
`ifdef AD9434_RAMP_CHK_EN
    ,
    output logic [15:0]            ramp_err_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam int EW = 64 + 4 + 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t state, state_nx;

    // ---------------- stage A: input register ----------------
    logic [5:0] a_q1, a_q2;
    logic       a_or;
    logic       a_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q1  <= '0;
            a_q2  <= '0;
            a_or  <= 1'b0;
            a_vld <= 1'b0;
        end else begin
            a_q1  <= q1;
            a_q2  <= q2;
            a_or  <= or_q1 | or_q2;
            // only pairs presented while capturing belong to the frame,
            // so the pair seen during the start cycle itself is skipped
            a_vld <= (state == CAPTURE);
        end
    end

    // ---------------- sample formation ----------------
    logic [11:0] a_raw;
    logic [11:0] a_fmt;
    logic [15:0] a_ext;

    always_comb begin
        a_raw = {a_q1, a_q2};
        a_fmt = '0;
        a_ext = '0;
        if (SWAP_HALVES != 0) begin
            a_raw = {a_q2, a_q1};
        end
        if (TWOS_COMP != 0) begin
            a_fmt = a_raw ^ 12'h800;
            a_ext = {{4{a_fmt[11]}}, a_fmt};
        end else begin
            a_fmt = a_raw;
            a_ext = {4'h0, a_fmt};
        end
    end

    // ---------------- control ----------------
    logic [1:0]             lane;
    logic [FRAME_LEN_W-1:0] word_cnt;
    logic [FRAME_LEN_W-1:0] len_q;
    logic                   start_ok;
    logic                   arm;
    logic                   abort;
    logic                   pack;
    logic                   word_done;
    logic                   is_last;

    // FIFO-side status needed by the FSM
    logic [AW:0] fifo_cnt;
    logic        wr_pend;

    always_comb begin
        start_ok  = start && enable && (frame_len != '0);
        arm       = (state == IDLE) && start_ok;
        abort     = (state == CAPTURE) && !enable;
        pack      = (state == CAPTURE) && enable && a_vld;
        word_done = pack && (lane == 2'd3);
        is_last   = word_done && (word_cnt == (len_q - 1'b1));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!enable || is_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_cnt == '0) && !wr_pend) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- lane packing ----------------
    logic [47:0] lanes;
    logic [2:0]  user_acc;
    logic [63:0] wr_data;
    logic [3:0]  wr_user;
    logic        wr_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane     <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            lanes    <= '0;
            user_acc <= '0;
            wr_data  <= '0;
            wr_user  <= '0;
            wr_last  <= 1'b0;
            wr_pend  <= 1'b0;
        end else begin
            // completed word reaches the FIFO one cycle after lane 3
            wr_pend <= word_done;
            if (arm) begin
                len_q    <= frame_len;
                word_cnt <= '0;
                lane     <= '0;
            end else if (abort) begin
                // partial word is thrown away
                lane <= '0;
            end else if (pack) begin
                lane <= lane + 2'd1;
                unique case (lane)
                    2'd0: begin
                        lanes[15:0] <= a_ext;
                        user_acc[0] <= a_or;
                    end
                    2'd1: begin
                        lanes[31:16] <= a_ext;
                        user_acc[1]  <= a_or;
                    end
                    2'd2: begin
                        lanes[47:32] <= a_ext;
                        user_acc[2]  <= a_or;
                    end
                    default: begin
                        wr_data  <= {a_ext, lanes};
                        wr_user  <= {a_or, user_acc};
                        wr_last  <= is_last;
                        word_cnt <= word_cnt + 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- output FIFO (first-word fall-through) ----------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] rd_word;
    logic          rd_fire;
    logic          wr_ok;
    logic          wr_drop;

    always_comb begin
        rd_word  = mem[rd_ptr];
        m_tvalid = (fifo_cnt != '0);
        rd_fire  = m_tvalid && m_tready;
        // a read in the same cycle frees the slot for a full-FIFO write
        wr_ok    = wr_pend && ((fifo_cnt != FULL_CNT) || rd_fire);
        wr_drop  = wr_pend && !wr_ok;
        m_tdata  = m_tvalid ? rd_word[63:0]  : '0;
        m_tuser  = m_tvalid ? rd_word[67:64] : '0;
        m_tlast  = m_tvalid ? rd_word[68]    : 1'b0;
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {wr_last, wr_user, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + {{AW{1'b0}}, wr_ok}
                                 - {{AW{1'b0}}, rd_fire};
        end
    end

    // ---------------- overflow tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else if (arm) begin
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
            if (ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

`ifdef AD9434_RAMP_CHK_EN
    // ---------------- ramp checker ----------------
    logic [11:0] ramp_prev;
    logic        ramp_seeded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_prev    <= '0;
            ramp_seeded  <= 1'b0;
            ramp_err_cnt <= '0;
        end else if (arm) begin
            ramp_seeded  <= 1'b0;
            ramp_err_cnt <= '0;
        end else if (pack) begin
            // first sample of a frame only seeds the expected value
            ramp_prev   <= a_raw;
            ramp_seeded <= 1'b1;
            if (ramp_seeded && (a_raw != 12'(ramp_prev + 12'd1))
                && (ramp_err_cnt != 16'hFFFF)) begin
                ramp_err_cnt <= ramp_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ad9434_sample_packer.md
Name: ad9434_sample_packer

Overview:
- Sits directly downstream of the AD9434 LVDS capture stage (IBUFDS/BUFR/IDDR); runs in the DCO-derived clock domain.
- Each clk cycle: takes one IDDR Q1/Q2 6-bit pair plus the overrange pair and rebuilds a 12-bit sample.
- Packs 4 samples into a 64-bit AXI-Stream word and buffers words in a small FIFO.
- Frames a software-armed capture of frame_len words, with tlast on the final word.

Parameters:
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥4).
- FRAME_LEN_W, 16, width of the frame_len word count.
- SWAP_HALVES, 0; 0: sample = {q1,q2}; 1: sample = {q2,q1}.
- TWOS_COMP, 1; 1: invert sample MSB (offset binary → two's complement); 0: pass through.

Ports:
- clk  in  1  DCO-derived clock (BUFR output domain).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable; low aborts a capture.
- start  in  1  single-cycle arm/start pulse.
- frame_len  in  FRAME_LEN_W  words per frame; sampled on start.
- q1  in  6  IDDR Q1 (rising-edge half, D6..D11).
- q2  in  6  IDDR Q2 (falling-edge half, D0..D5).
- or_q1, or_q2  in  1 each  IDDR overrange outputs.
- m_tdata  out  64  4 lanes × 16 bits; lane0 [15:0] holds the oldest sample.
- m_tuser  out  4  per-lane overrange flag (or_q1|or_q2).
- m_tvalid  out  1  AXI-Stream valid.
- m_tready  in  1  AXI-Stream ready.
- m_tlast  out  1  final word of frame.
- busy  out  1  high when the FSM is not IDLE.
- overflow  out  1  sticky; set on any dropped word; cleared only by start or reset.
- ovf_cnt  out  16  dropped-word count; saturates at 0xFFFF; cleared by start.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; FIFO empty; lane counter and word counter 0.
- Sample formation:
  - Input registered once (stage A).
  - 12-bit sample per SWAP_HALVES, then MSB inverted if TWOS_COMP=1.
  - Sign-extended to 16 bits if TWOS_COMP=1, else zero-extended.
- Packing: 2-bit lane counter fills lanes 0..3, one per cycle while CAPTURE. On lane 3 the word and its tuser are written to the FIFO next cycle.
- FSM:
  - IDLE: start & enable & frame_len≠0 → CAPTURE. On that transition: latch frame_len, clear overflow/ovf_cnt, word_cnt=0, lane=0. The q pair presented in the cycle after start is lane0 of word0. start with frame_len=0 or enable=0 is ignored.
  - CAPTURE: each completed word increments word_cnt. The word with word_cnt==len-1 is written with last=1 and the FSM goes to DRAIN. start is ignored while not IDLE.
  - CAPTURE with enable=0: abort. Partial word discarded, no tlast, → DRAIN.
  - DRAIN: no new writes. → IDLE when the FIFO is empty and no beat is pending.
- Latency: 4th sample on q at cycle t → m_tvalid high in cycle t+3 if the FIFO was empty and m_tready was irrelevant beforehand.
- Handshake: beat transfers when m_tvalid & m_tready. While m_tvalid=1 and m_tready=0, m_tdata/m_tuser/m_tlast are held stable. Output is FIFO read-ahead (first-word fall-through, registered).
- Full FIFO at write: word dropped but still counted toward frame_len; overflow=1; ovf_cnt+1 (saturating). If the dropped word is the last word, the frame ends without tlast; overflow flags it.
- Simultaneous read and write when full: the write succeeds (a read frees the slot in the same cycle).
- Reset mid-frame: immediate return to reset values; FIFO contents lost.

Optional Feature:
- Macro AD9434_RAMP_CHK_EN.
- Defined:
  - Adds output port ramp_err_cnt [15:0] (saturating, cleared by start).
  - In CAPTURE, each raw 12-bit sample (before TWOS_COMP) is compared with previous+1 mod 4096. The first sample of a frame only seeds the checker.
  - Each mismatch increments ramp_err_cnt.
- Undefined: port and checker logic absent; all other behaviour identical.

Test Plan:
- Format: TWOS_COMP=1, SWAP=0, q1=6'h3F, q2=6'h00 constant, frame_len=1, m_tready=1 → one beat, m_tdata=64'h07C0_07C0_07C0_07C0, m_tlast=1, m_tuser=0; busy falls after the beat.
- Ordering/latency: ramp 0,1,2,3 on {q1,q2} (TWOS_COMP=0) → m_tdata=64'h0003_0002_0001_0000, m_tvalid exactly 3 cycles after sample 3; or_q2=1 on sample 2 → m_tuser=4'b0100.
- Frame: frame_len=5, m_tready=1 → exactly 5 beats, tlast only on beat 5; second start during CAPTURE ignored.
- Backpressure/overflow: m_tready=0, frame_len=20, FIFO_DEPTH=16 → 16 words stored, 4 dropped, overflow=1, ovf_cnt=4, no tlast; then m_tready=1 → 16 beats with stable data under stalls; next start clears overflow.
- Abort/reset: enable low after 2 samples of word 3 → words 0–2 delivered, no tlast, partial discarded, busy=0 after drain; rst_n low mid-frame → all outputs 0 immediately.
- With AD9434_RAMP_CHK_EN: ramp with one skipped value at sample 10 → ramp_err_cnt=1; clean ramp → 0.
